cmd_packet_encoder: RTL and testbench

Host-side packet builder producing the 9-byte command stream consumed by the serial-pattern receiver/decoder chain. It accepts one command (FREQ or DATA) per handshake, serialises it into bytes with a trailing XOR checksum, and drives a byte-wide UART transmitter through a start-tick/done-tick handshake. It sits between a command source (test sequencer or CPU register bank) and the uart_tx instance.

---
 rtl/cmd_packet_encoder_pkg.sv | 48 ++++
 rtl/cmd_packet_encoder_if.sv | 30 +++
 rtl/cmd_packet_encoder_pkt_assemble.sv | 47 ++++
 rtl/cmd_packet_encoder.sv | 113 +++++++++++
 tb/tb_cmd_packet_encoder.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_packet_encoder_pkg.sv
// cmd_packet_encoder_pkg
//   Constants and types shared by the command packet encoder and the remote
//   decoder chain: command codes, packet geometry, byte offsets inside a
//   packet, control-byte bit positions and the encoder FSM states.
package cmd_packet_encoder_pkg;

  localparam int DATA_BIT = 32;
  localparam int PACK_NUM = 9;
  localparam int SEL_BIT  = 4;
  localparam int PKT_BITS = PACK_NUM * 8;

  localparam logic [7:0] CMD_FREQ = 8'h0A;
  localparam logic [7:0] CMD_DATA = 8'h0B;

  // Byte offsets, byte 0 is transmitted first.
  localparam int B_CMD  = 0;
  localparam int B_PAT0 = 1;
  localparam int B_CTRL = 5;
  localparam int B_AUX  = 6;
  localparam int B_PAD  = 7;
  localparam int B_CHK  = 8;

  // Bit positions inside the DATA control byte.
  localparam int CTRL_START   = 0;
  localparam int CTRL_STOP    = 1;
  localparam int CTRL_MODE    = 2;
  localparam int CTRL_SEL_LSB = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic is_known_cmd(input logic [7:0] code);
    return (code == CMD_FREQ) || (code == CMD_DATA);
  endfunction

  // Byte idx of a packet; the packet is stored with byte 0 in the top bits.
  function automatic logic [7:0] get_pkt_byte(input logic [PKT_BITS-1:0] pkt,
                                              input logic [3:0] idx);
    logic [PKT_BITS-1:0] sh;
    sh = pkt << (8 * idx);
    return sh[PKT_BITS-1 -: 8];
  endfunction

endpackage

// File: rtl/cmd_packet_encoder_if.sv
// cmd_packet_encoder_if
//   Command bus between a command source and the packet encoder.
//   master: drives cmd_valid and the command fields, receives cmd_ready.
//   slave : receives the command, drives cmd_ready.
//   Fields: cmd (code), pattern, sel_out/start/stop/mode (DATA),
//   slow_period/fast_period (FREQ).
interface cmd_packet_encoder_if import cmd_packet_encoder_pkg::*; ();
  logic                cmd_valid;
  logic                cmd_ready;
  logic [7:0]          cmd;
  logic [DATA_BIT-1:0] pattern;
  logic [SEL_BIT-1:0]  sel_out;
  logic                start;
  logic                stop;
  logic                mode;
  logic [7:0]          slow_period;
  logic [7:0]          fast_period;

  modport master (
    output cmd_valid, cmd, pattern, sel_out, start, stop, mode,
           slow_period, fast_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd, pattern, sel_out, start, stop, mode,
           slow_period, fast_period,
    output cmd_ready
  );
endinterface

// File: rtl/cmd_packet_encoder_pkt_assemble.sv
// pkt_assemble
//   Purely combinational mapping of command fields to the 72-bit packet
//   (byte 0 in bits [71:64]) including the trailing XOR checksum.
//   Inputs : cmd, pattern, sel_out, start, stop, mode, slow_period, fast_period
//   Output : packet
module pkt_assemble import cmd_packet_encoder_pkg::*; (
  input  logic [7:0]          cmd,
  input  logic [DATA_BIT-1:0] pattern,
  input  logic [SEL_BIT-1:0]  sel_out,
  input  logic                start,
  input  logic                stop,
  input  logic                mode,
  input  logic [7:0]          slow_period,
  input  logic [7:0]          fast_period,
  output logic [PKT_BITS-1:0] packet
);

  logic [7:0]  data_ctrl;
  logic [7:0]  ctrl_byte;
  logic [7:0]  aux_byte;
  logic [63:0] body;
  logic [7:0]  chk_byte;

  always_comb begin
    data_ctrl                            = 8'h00;
    data_ctrl[CTRL_START]                = start;
    data_ctrl[CTRL_STOP]                 = stop;
    data_ctrl[CTRL_MODE]                 = mode;
    data_ctrl[CTRL_SEL_LSB +: SEL_BIT]   = sel_out;
  end

  // Anything that is not DATA is laid out as FREQ; unknown codes never
  // reach the packet register, so their layout does not matter.
  assign ctrl_byte = (cmd == CMD_DATA) ? data_ctrl : slow_period;
  assign aux_byte  = (cmd == CMD_DATA) ? 8'h00     : fast_period;
  assign body      = {cmd, pattern, ctrl_byte, aux_byte, 8'h00};

  always_comb begin
    chk_byte = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk_byte = chk_byte ^ body[i*8 +: 8];
    end
  end

  assign packet = {body, chk_byte};

endmodule

// File: rtl/cmd_packet_encoder.sv
// cmd_packet_encoder
//   Accepts one FREQ/DATA command per handshake, latches the 9-byte packet
//   and feeds it byte by byte to an external UART transmitter.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   cmd_bus (slave)   : command handshake and fields
//   tx_data_o         : byte being transmitted, held until tx_done_tick_i
//   tx_start_tick_o   : one-cycle launch pulse per byte
//   tx_done_tick_i    : transmitter finished the current byte
//   busy_o            : packet in flight
//   done_tick_o       : pulse after the last byte completed
//   err_tick_o        : pulse for each cycle an unknown code is offered in idle
module cmd_packet_encoder import cmd_packet_encoder_pkg::*; (
  input  logic                 clk_i,
  input  logic                 rst_i,
  cmd_packet_encoder_if.slave  cmd_bus,
  output logic [7:0]           tx_data_o,
  output logic                 tx_start_tick_o,
  input  logic                 tx_done_tick_i,
  output logic                 busy_o,
  output logic                 done_tick_o,
  output logic                 err_tick_o
);

  state_t              state_reg, state_next;
  logic [PKT_BITS-1:0] packet_reg;
  logic [PKT_BITS-1:0] packet_asm;
  logic [3:0]          index_reg;
  logic [7:0]          tx_data_reg;
  logic                err_reg;
  logic                accept;
  logic                reject;
  logic                last_byte;
  logic                advance;
  logic                cmd_ready;

  pkt_assemble u_pkt_assemble (
    .cmd         (cmd_bus.cmd),
    .pattern     (cmd_bus.pattern),
    .sel_out     (cmd_bus.sel_out),
    .start       (cmd_bus.start),
    .stop        (cmd_bus.stop),
    .mode        (cmd_bus.mode),
    .slow_period (cmd_bus.slow_period),
    .fast_period (cmd_bus.fast_period),
    .packet      (packet_asm)
  );

  assign accept    = (state_reg == S_IDLE) && cmd_bus.cmd_valid &&  is_known_cmd(cmd_bus.cmd);
  assign reject    = (state_reg == S_IDLE) && cmd_bus.cmd_valid && !is_known_cmd(cmd_bus.cmd);
  assign last_byte = (index_reg == 4'(PACK_NUM - 1));
  assign advance   = (state_reg == S_WAIT) && tx_done_tick_i && !last_byte;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (accept) state_next = S_SEND;
      S_SEND: state_next = S_WAIT;
      S_WAIT: if (tx_done_tick_i) state_next = last_byte ? S_DONE : S_SEND;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: the outgoing byte is loaded together with the transition into
  // S_SEND, so tx_data_o is a register and stays put until the done tick.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      packet_reg  <= '0;
      index_reg   <= 4'd0;
      tx_data_reg <= 8'h00;
      err_reg     <= 1'b0;
    end else begin
      err_reg <= reject;
      if (accept) begin
        packet_reg  <= packet_asm;
        index_reg   <= 4'd0;
        tx_data_reg <= get_pkt_byte(packet_asm, 4'd0);
      end else if (advance) begin
        index_reg   <= index_reg + 4'd1;
        tx_data_reg <= get_pkt_byte(packet_reg, index_reg + 4'd1);
      end
    end
  end

  // Output decode from registers only
  always_comb begin
    cmd_ready       = 1'b0;
    tx_start_tick_o = 1'b0;
    busy_o          = 1'b1;
    done_tick_o     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy_o    = 1'b0;
      end
      S_SEND: tx_start_tick_o = 1'b1;
      S_DONE: done_tick_o     = 1'b1;
      default: ;
    endcase
  end

  assign cmd_bus.cmd_ready = cmd_ready;
  assign tx_data_o         = tx_data_reg;
  assign err_tick_o        = err_reg;

endmodule

// File: tb/tb_cmd_packet_encoder.sv
module tb_cmd_packet_encoder;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [7:0] tx_data_o;
  logic       tx_start_tick_o;
  logic       tx_done_tick_i = 1'b0;
  logic       busy_o;
  logic       done_tick_o;
  logic       err_tick_o;

  cmd_packet_encoder_if bus ();

  cmd_packet_encoder dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .cmd_bus         (bus),
    .tx_data_o       (tx_data_o),
    .tx_start_tick_o (tx_start_tick_o),
    .tx_done_tick_i  (tx_done_tick_i),
    .busy_o          (busy_o),
    .done_tick_o     (done_tick_o),
    .err_tick_o      (err_tick_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  int         exp_done = 0;
  int         done_count = 0;
  int         err_count = 0;
  int         start_count = 0;
  int         byte_in_pkt = 0;
  int         last_done_cyc = -100;
  int         tx_lat = 3;
  bit         tx_rand = 1'b0;
  bit         tx_spurious = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference packet: bytes laid out from the command fields, XOR checksum last.
  function automatic logic [71:0] model_pkt(input logic [7:0] c, input logic [31:0] pat,
                                            input logic [3:0] sel, input bit st, input bit sp,
                                            input bit md, input logic [7:0] slow,
                                            input logic [7:0] fast);
    logic [7:0]  b[9];
    logic [71:0] r;
    b[0] = c;
    for (int i = 0; i < 4; i++) b[1+i] = 8'(pat >> (8 * (3 - i)));
    if (c == 8'h0B) begin
      b[5] = {sel, 1'b0, md, sp, st};
      b[6] = 8'h00;
    end else begin
      b[5] = slow;
      b[6] = fast;
    end
    b[7] = 8'h00;
    b[8] = 8'h00;
    for (int i = 0; i < 8; i++) b[8] = b[8] ^ b[i];
    r = '0;
    for (int i = 0; i < 9; i++) r = (r << 8) | 72'(b[i]);
    return r;
  endfunction

  task automatic push_bytes(input logic [71:0] v);
    for (int i = 0; i < 9; i++) exp_q.push_back(v[71 - 8*i -: 8]);
    exp_done++;
  endtask

  task automatic wait_ready(input int bound);
    int n = 0;
    while (!bus.cmd_ready && n < bound) begin
      @(negedge clk_i);
      n++;
    end
    if (!bus.cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: cmd_ready still 0 after %0d cycles", bound);
    end
  endtask

  task automatic drive(input logic [7:0] c, input logic [31:0] pat, input logic [3:0] sel,
                       input bit st, input bit sp, input bit md,
                       input logic [7:0] slow, input logic [7:0] fast);
    bus.cmd         = c;
    bus.pattern     = pat;
    bus.sel_out     = sel;
    bus.start       = st;
    bus.stop        = sp;
    bus.mode        = md;
    bus.slow_period = slow;
    bus.fast_period = fast;
    bus.cmd_valid   = 1'b1;
  endtask

  // One command through the handshake; expected bytes come from the model
  // unless a literal packet is supplied.
  task automatic send(input logic [7:0] c, input logic [31:0] pat, input logic [3:0] sel,
                      input bit st, input bit sp, input bit md,
                      input logic [7:0] slow, input logic [7:0] fast,
                      input bit use_lit, input logic [71:0] lit);
    wait_ready(4000);
    drive(c, pat, sel, st, sp, md, slow, fast);
    push_bytes(use_lit ? lit : model_pkt(c, pat, sel, st, sp, md, slow, fast));
    @(negedge clk_i);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, "_tx_data"}, 32'(tx_data_o), 32'd0);
    check({tag, "_tx_start"}, 32'(tx_start_tick_o), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(done_tick_o), 32'd0);
    check({tag, "_err"}, 32'(err_tick_o), 32'd0);
  endtask

  // Transmitter model: done tick T cycles after each start tick; optionally
  // repeats the done tick one extra cycle, which lands in S_SEND or S_DONE.
  initial begin : tx_model
    int         cnt;
    bit         done_prev;
    bit         nd;
    logic [7:0] held;
    cnt = 0;
    done_prev = 1'b0;
    held = 8'h00;
    forever begin
      @(negedge clk_i);
      nd = 1'b0;
      if (rst_i) begin
        cnt = 0;
        done_prev = 1'b0;
      end else begin
        if (tx_spurious && done_prev) nd = 1'b1;
        done_prev = 1'b0;
        if (tx_start_tick_o) begin
          held = tx_data_o;
          cnt = tx_rand ? int'($urandom_range(200, 1)) : tx_lat;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            nd = 1'b1;
            done_prev = 1'b1;
            last_done_cyc = cyc;
            check("tx_data_hold", 32'(tx_data_o), 32'(held));
          end
        end
      end
      tx_done_tick_i = nd;
    end
  end

  // Monitor: pops the scoreboard on every start tick.
  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        byte_in_pkt = 0;
      end else begin
        if (tx_start_tick_o) begin
          start_count++;
          if (byte_in_pkt > 0) check("start_spacing", 32'(cyc), 32'(last_done_cyc + 1));
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start: byte %0h sent with empty scoreboard", tx_data_o);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("byte%0d", byte_in_pkt), 32'(tx_data_o), 32'(e));
          end
          byte_in_pkt++;
        end
        if (done_tick_o) begin
          done_count++;
          check("done_after_9", 32'(byte_in_pkt), 32'd9);
          check("done_timing", 32'(cyc), 32'(last_done_cyc + 1));
          byte_in_pkt = 0;
        end
        if (err_tick_o) err_count++;
      end
    end
  end

  initial begin : watchdog
    #(10 * 80000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int e0, s0, n;
    bus.cmd_valid = 1'b0;
    drive(8'h00, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    bus.cmd_valid = 1'b0;

    #2 rst_i = 1'b1;
    #1 check_reset_outputs("por");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Fixed vectors with hand-computed packets
    tx_lat = 3;
    send(8'h0B, 32'h12345678, 4'd3, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 72'h0B_12345678_35_00_00_36);
    send(8'h0A, 32'h0000FFFF, 4'd0, 1'b0, 1'b0, 1'b0, 8'h14, 8'h05, 1'b1, 72'h0A_0000FFFF_14_05_00_1B);
    wait_ready(4000);
    repeat (2) @(negedge clk_i);
    check("done_count_vectors", 32'(done_count), 32'd2);

    // Unknown code held valid for three cycles
    e0 = err_count;
    s0 = start_count;
    drive(8'h55, 32'hDEADBEEF, 4'd1, 1'b1, 1'b1, 1'b1, 8'h01, 8'h02);
    repeat (3) begin
      @(negedge clk_i);
      check("ready_invalid", 32'(bus.cmd_ready), 32'd1);
    end
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk_i);
    check("err_pulses", 32'(err_count - e0), 32'd3);
    check("no_start_invalid", 32'(start_count - s0), 32'd0);

    // Inputs scrambled and valid held during a packet, spurious done ticks
    tx_lat = 4;
    tx_spurious = 1'b1;
    send(8'h0B, $urandom(), 4'($urandom_range(15, 0)), 1'($urandom), 1'($urandom), 1'($urandom),
         8'($urandom), 8'($urandom), 1'b0, 72'h0);
    e0 = err_count;
    repeat (8) begin
      drive(8'($urandom), $urandom(), 4'($urandom_range(15, 0)), 1'($urandom), 1'($urandom),
            1'($urandom), 8'($urandom), 8'($urandom));
      @(negedge clk_i);
    end
    drive(8'h0A, $urandom(), 4'($urandom_range(15, 0)), 1'($urandom), 1'($urandom), 1'($urandom),
          8'($urandom), 8'($urandom));
    push_bytes(model_pkt(bus.cmd, bus.pattern, bus.sel_out, bus.start, bus.stop, bus.mode,
                         bus.slow_period, bus.fast_period));
    n = 0;
    while (!done_tick_o && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    check("ready_in_done", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk_i);
    check("ready_after_done", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk_i);
    check("held_cmd_accepted", 32'(busy_o), 32'd1);
    bus.cmd_valid = 1'b0;
    check("no_err_while_busy", 32'(err_count - e0), 32'd0);
    wait_ready(4000);
    tx_spurious = 1'b0;

    // Reset in the middle of a packet
    tx_lat = 3;
    send(8'h0B, $urandom(), 4'($urandom_range(15, 0)), 1'($urandom), 1'($urandom), 1'($urandom),
         8'h00, 8'h00, 1'b0, 72'h0);
    n = 0;
    while (byte_in_pkt < 5 && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    #2;
    check("busy_before_reset", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    #1 check_reset_outputs("midrst");
    exp_q.delete();
    exp_done--;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    send(8'h0A, $urandom(), 4'd0, 1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 1'b0, 72'h0);
    wait_ready(4000);

    // Back-to-back DATA packets over every channel, random transmitter latency
    tx_rand = 1'b1;
    for (int s = 0; s < 16; s++) begin
      send(8'h0B, $urandom(), 4'(s), 1'($urandom), 1'($urandom), 1'($urandom),
           8'($urandom), 8'($urandom), 1'b0, 72'h0);
    end
    wait_ready(4000);
    repeat (3) @(negedge clk_i);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("done_count_total", 32'(done_count), 32'(exp_done));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
